// File: rtl/register_file_bypass.sv
// rtl/register_file_bypass.sv - register file with write forwarding, jal link write and a register dump engine
module register_file_bypass #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 1,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              reg_write,
    input  logic              jal,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dump_state_t;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] w_stored [DEPTH];

    dump_state_t       r_state;
    dump_state_t       w_state_next;
    logic [ADDR_W-1:0] r_dump_addr;
    logic [DATA_W-1:0] r_dump_data;

    logic              w_zero_en;
    logic              w_wr_en;
    logic              w_jal_en;
    logic [DATA_W-1:0] w_link;
    logic              w_start;
    logic              w_xfer;
    logic              w_last;
    logic [ADDR_W-1:0] w_next_addr;

    // Register 0 is only forced to zero when the hardwired-zero option is on.
    assign w_zero_en = (ZERO_REG != 0);

    // A write commits only when not paused; writes aimed at a hardwired zero are dropped here.
    assign w_wr_en  = reg_write && !pause && !(w_zero_en && (wr_addr == '0));
    assign w_jal_en = jal && !pause && !(w_zero_en && (LINK_IDX == '0));
    assign w_link   = pc + DATA_W'(LINK_OFFSET);

    // Stored view of the array, with register 0 masked to zero when hardwired.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_stored[i] = r_regs[i];
        end
        if (w_zero_en) begin
            w_stored[0] = '0;
        end
    end

    // Register array update; the explicit write is applied after jal so it wins on LINK_REG.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_jal_en) begin
                r_regs[LINK_IDX] <= w_link;
            end
            if (w_wr_en) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Read port rs: stored value, overridden by a write committing this edge when forwarding is on.
    always_comb begin
        rs_data = w_stored[rs_addr];
        if (BYPASS != 0) begin
            if (w_wr_en && (wr_addr == rs_addr)) begin
                rs_data = wr_data;
            end else if (w_jal_en && (LINK_IDX == rs_addr)) begin
                rs_data = w_link;
            end
        end
    end

    // Read port rt: same forwarding priority as rs.
    always_comb begin
        rt_data = w_stored[rt_addr];
        if (BYPASS != 0) begin
            if (w_wr_en && (wr_addr == rt_addr)) begin
                rt_data = wr_data;
            end else if (w_jal_en && (LINK_IDX == rt_addr)) begin
                rt_data = w_link;
            end
        end
    end

    assign w_start     = (r_state == ST_IDLE) && dump_start && !pause;
    assign w_xfer      = dump_valid && dump_ready;
    assign w_last      = (r_dump_addr == LAST_IDX);
    assign w_next_addr = r_dump_addr + ADDR_W'(1);

    // Dump state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dump next-state logic: start from IDLE, leave RUN after the final beat is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_xfer && w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Dump outputs: a beat is offered whenever running and not paused.
    always_comb begin
        dump_busy  = (r_state == ST_RUN);
        dump_valid = (r_state == ST_RUN) && !pause;
    end

    // Dump beat registers: captured from pre-write storage and held between transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else if (w_start) begin
            r_dump_addr <= '0;
            r_dump_data <= w_stored[0];
        end else if (w_xfer) begin
            r_dump_addr <= w_next_addr;
            if (!w_last) begin
                r_dump_data <= w_stored[w_next_addr];
            end
        end
    end

    assign dump_addr = r_dump_addr;
    assign dump_data = r_dump_data;

endmodule
